mem_block_mover: RTL
====================

# mem_block_mover

Multi-cycle initiator for the MIPS data memory port. It performs block copy and block fill operations on the 32-word data memory by driving the memory's address, write data, write enable and read enable, and by sampling its read data. It sits beside the datapath as a small DMA engine and owns the data memory port only while `busy` is high; an external mux selects between datapath and mover. It also reports a running 32-bit sum of the words written, used as a transfer checksum.

## Interface
- `ADDR_W`, default 5: memory word-address width; memory depth is 2^ADDR_W words.
- `DATA_W`, default 32: data word width.

- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `mode` input 1: 0 = copy, 1 = fill; captured with `start`.
- `src_addr` input ADDR_W: copy source base; captured with `start`.
- `dst_addr` input ADDR_W: destination base; captured with `start`.
- `len` input ADDR_W+1: word count, 0..32; captured with `start`.
- `fill_value` input DATA_W: fill word; captured with `start`.
- `busy` output 1: high in every state other than IDLE.
- `done` output 1: one-cycle completion pulse.
- `sum` output DATA_W: modulo-2^DATA_W sum of all words written by the current or last operation.
- `mem_address` output ADDR_W: memory word address.
- `mem_writedata` output DATA_W: memory write data.
- `mem_memwr` output 1: memory write enable; the memory writes on the rising edge.
- `mem_memrd` output 1: memory read enable; the memory returns data combinationally.
- `mem_readdata` input DATA_W: memory read data; 0 when `mem_memrd` is low.

## Operation
- States are IDLE, RD, WR and DONE.
- Registers: captured operands, index `i` (ADDR_W+1 bits), data buffer `buf`, and `sum`.
- All memory-side outputs and `busy`/`done` are decoded from registered state only. There is no combinational path from any input to any output.
- **IDLE**
  - All memory outputs are 0.
  - When `start` is 1, capture the operands, set `i`=0 and `sum`=0.
  - If `len`=0, go to DONE.
  - Otherwise go to WR if `mode`=1, or RD if `mode`=0.
- **RD** (copy only)
  - `mem_memrd`=1 and `mem_address`=src+i.
  - On the clock edge, `buf` <= `mem_readdata`, then go to WR.
- **WR**
  - `mem_memwr`=1 and `mem_address`=dst+i.
  - `mem_writedata`=`buf` in copy mode, or the captured `fill_value` in fill mode.
  - On the clock edge, `sum` += `mem_writedata` and `i`++.
  - If the new `i` equals `len`, go to DONE. Otherwise go to RD (copy) or stay in WR (fill).
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W: base+i wraps, so dst=30 with len=4 writes 30, 31, 0, 1.
- Copies always run in ascending index order. Overlapping regions are legal; when dst>src the source data propagates forward. No overlap detection is performed.
- `start` outside IDLE is ignored. Operands are not re-sampled while busy.
- `sum` holds its value after DONE until the next accepted `start`.

## Timing
- Reset (`rst_n`=0, asynchronous) immediately forces:
  - state = IDLE;
  - `busy`, `done`, `mem_memwr`, `mem_memrd` = 0;
  - `mem_address`, `mem_writedata`, `sum`, `i`, `buf` = 0.
- Reset mid-operation aborts the operation. A write pending in the current cycle is not committed, because `mem_memwr` drops asynchronously.
- Copy latency: `done` is high during cycle 2·len+1 after the edge that samples `start` (RD and WR take one cycle each per word).
- Fill latency: `done` is high during cycle len+1.
- len=0: `done` is high in cycle 1, with no memory access.
- `busy` rises in cycle 1 and falls in the cycle after `done`. A new `start` is accepted in the first IDLE cycle after `done`.

## Test plan
- **Copy.** Memory preloaded with mem[1..10]=3..12. Copy src=1, dst=20, len=3 -> mem[20..22]=3,4,5; sum=12; `done` in cycle 7; exactly 3 `mem_memrd` cycles and 3 `mem_memwr` cycles.
- **Fill with wrap.** Fill dst=30, len=4, fill_value=0xA5 -> mem[30], mem[31], mem[0], mem[1] all 0xA5; sum=0x294; `done` in cycle 5; `mem_memrd` never asserted.
- **Overlapping copy.** With mem[2]=4, mem[3]=5, copy src=2, dst=3, len=3 -> mem[3..5]=4,4,4; sum=12.
- **Zero length and ignored start.** len=0 -> `done` in cycle 1, no memory enables, sum=0. A second `start` pulsed mid-copy is ignored, and `done` timing and results are unchanged.
- **Reset mid-operation.** Drop `rst_n` during the second WR of a len=3 copy -> `mem_memwr` and `busy` go to 0 in the same cycle; only the first destination word is written; sum=0; the next `start` runs normally.
- **Full-memory fill.** len=32 fill -> all 32 words written, `i` does not overflow, `done` in cycle 33.

Source files
------------

// File: rtl/mem_block_mover.sv
// Block copy / block fill initiator for the data memory port. Owns the port while busy_o is high
// and keeps a running sum of the words written as a transfer checksum.
module mem_block_mover #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [DATA_W-1:0] fill_value_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] sum_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_writedata_o,
  output logic              mem_memwr_o,
  output logic              mem_memrd_o,
  input  logic [DATA_W-1:0] mem_readdata_i
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e              state_q;
  logic                mode_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [ADDR_W:0]     len_q;
  logic [DATA_W-1:0]   fill_q;
  logic [ADDR_W:0]     i_q;
  logic [DATA_W-1:0]   buf_q;
  logic [DATA_W-1:0]   sum_q;

  logic [ADDR_W:0]     i_next;
  logic [DATA_W-1:0]   wr_word;

  assign i_next  = i_q + 1'b1;
  assign wr_word = mode_q ? fill_q : buf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      i_q     <= '0;
      buf_q   <= '0;
      sum_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            mode_q <= mode_i;
            src_q  <= src_addr_i;
            dst_q  <= dst_addr_i;
            len_q  <= len_i;
            fill_q <= fill_value_i;
            i_q    <= '0;
            sum_q  <= '0;
            if (len_i == '0) begin
              state_q <= StDone;
            end else begin
              state_q <= mode_i ? StWr : StRd;
            end
          end
        end
        StRd: begin
          buf_q   <= mem_readdata_i;
          state_q <= StWr;
        end
        StWr: begin
          sum_q <= sum_q + wr_word;
          i_q   <= i_next;
          // i is one bit wider than the address so len=32 terminates without overflow
          if (i_next == len_q) begin
            state_q <= StDone;
          end else begin
            state_q <= mode_q ? StWr : StRd;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so reset drops the enables asynchronously.
  always_comb begin
    busy_o          = 1'b0;
    done_o          = 1'b0;
    mem_address_o   = '0;
    mem_writedata_o = '0;
    mem_memwr_o     = 1'b0;
    mem_memrd_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StRd: begin
        busy_o        = 1'b1;
        mem_memrd_o   = 1'b1;
        mem_address_o = src_q + i_q[ADDR_W-1:0];
      end
      StWr: begin
        busy_o          = 1'b1;
        mem_memwr_o     = 1'b1;
        mem_address_o   = dst_q + i_q[ADDR_W-1:0];
        mem_writedata_o = wr_word;
      end
      StDone: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign sum_o = sum_q;

endmodule
